// File: rtl/data_ram_be.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_be
// Description : Word-organised data RAM with big-endian byte-lane write
//               enables. Writes are synchronous, reads are combinational.
//               Contents survive reset; reset only gates writes and the read
//               port.
// Revision    : 1.0 - initial release
// ============================================================================
module data_ram_be #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int MEM_NUM_LOG2 = 17,
  parameter int MEM_NUM      = 2 ** MEM_NUM_LOG2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        sel,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  localparam int c_LANES = 4;

  // Word index: byte offset bits are dropped, upper bits alias.
  logic [MEM_NUM_LOG2-1:0] w_idx;
  logic                    w_wr_en;
  logic                    w_rd_en;
  logic [DATA_W-1:0]       w_rd_word;
  logic                    w_unused_addr;

  assign w_idx   = addr[MEM_NUM_LOG2+1:2];
  // rst is active-low; while low it blocks writes and forces data_o to zero.
  assign w_wr_en = rst & ce & we;
  assign w_rd_en = rst & ce & ~we;

  // Address bits that intentionally take no part in decoding.
  assign w_unused_addr = ^{addr[ADDR_W-1:MEM_NUM_LOG2+2], addr[1:0]};

  // One byte-wide array per lane so synthesis maps onto byte-enabled BRAM.
  generate
    for (genvar gi = 0; gi < c_LANES; gi++) begin : g_lane
      logic [7:0] r_mem [MEM_NUM];

      // Commit this lane's byte when the write is enabled and the lane selected.
      always_ff @(posedge clk) begin
        if (w_wr_en && sel[gi]) begin
          r_mem[w_idx] <= data_i[8*gi +: 8];
        end
      end

      assign w_rd_word[8*gi +: 8] = r_mem[w_idx];
    end
  endgenerate

  // Read port: full word on a read, zero for idle, write or reset cycles.
  assign data_o = w_rd_en ? w_rd_word : '0;

endmodule
`default_nettype wire

// File: tb/tb_data_ram_be.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_ram_be
// Description : Scoreboard testbench for data_ram_be. A driver issues one
//               access per cycle and queues the expected data_o; a monitor
//               compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_ram_be;

  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 32;
  localparam int MEM_NUM_LOG2 = 17;
  localparam int MEM_NUM      = 2 ** MEM_NUM_LOG2;

  logic              clk = 1'b0;
  logic              rst;
  logic              ce;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        sel;
  logic [DATA_W-1:0] data_i;
  logic [DATA_W-1:0] data_o;

  int total = 0;
  int bad   = 0;

  // Expected-response scoreboard
  logic [31:0] q_exp  [$];
  bit          q_chk  [$];
  string       q_name [$];

  // Reference model: word index -> word, only for words with known contents
  logic [31:0] model [int];
  int          known_idx [8];

  always #5 clk = ~clk;

  data_ram_be #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .MEM_NUM_LOG2(MEM_NUM_LOG2),
    .MEM_NUM     (MEM_NUM)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ce    (ce),
    .we    (we),
    .addr  (addr),
    .sel   (sel),
    .data_i(data_i),
    .data_o(data_o)
  );

  // Monitor: data_o is combinational, so compare mid-cycle
  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      logic [31:0] e;
      bit          c;
      string       n;
      e = q_exp.pop_front();
      c = q_chk.pop_front();
      n = q_name.pop_front();
      if (c) begin
        total++;
        if (data_o !== e) begin
          bad++;
          $display("FAIL %s: data_o=%08h expected=%08h", n, data_o, e);
        end
      end
    end
  end

  // One access per cycle; expected value is queued, then the model updated
  task automatic step(input logic r, input logic c, input logic w,
                      input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input string nm);
    int          idx;
    logic [31:0] word;
    @(posedge clk);
    #1;
    rst = r; ce = c; we = w; addr = a; sel = s; data_i = d;
    idx = int'((a / 32'd4) % MEM_NUM);
    if (r && c && !w) begin
      if (model.exists(idx)) begin
        q_exp.push_back(model[idx]); q_chk.push_back(1'b1);
      end else begin
        q_exp.push_back(32'h0); q_chk.push_back(1'b0);
      end
    end else begin
      q_exp.push_back(32'h0); q_chk.push_back(1'b1);
    end
    q_name.push_back(nm);
    if (r && c && w) begin
      if (model.exists(idx)) begin
        word = model[idx];
        for (int i = 0; i < 4; i++)
          if (s[i]) word[8*i +: 8] = d[8*i +: 8];
        model[idx] = word;
      end else if (s == 4'hF) begin
        model[idx] = d;
      end
    end
  endtask

  task automatic rd(input logic [31:0] a, input string nm);
    step(1'b1, 1'b1, 1'b0, a, 4'h0, $urandom, nm);
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] s,
                    input logic [31:0] d, input string nm);
    step(1'b1, 1'b1, 1'b1, a, s, d, nm);
  endtask

  // Driver
  initial begin
    int op;
    int k;
    logic [31:0] a;
    rst = 1'b0; ce = 1'b0; we = 1'b0; addr = '0; sel = '0; data_i = '0;

    step(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, "reset_idle");
    step(1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, "reset_read");

    // Reset gating of writes
    wr(32'h0, 4'hF, 32'h11111111, "prewrite");
    step(1'b0, 1'b1, 1'b1, 32'h0, 4'hF, 32'hDEADBEEF, "reset_write");
    rd(32'h0, "reset_blocked_write");

    // Full-word write/read, offset ignored
    wr(32'h100, 4'hF, 32'h12345678, "full_write");
    rd(32'h100, "full_read");
    rd(32'h103, "offset_ignored");

    // Byte lanes
    wr(32'h100, 4'b1000, 32'hAABBCCDD, "lane3_write");
    wr(32'h100, 4'b0001, 32'hAABBCCDD, "lane0_write");
    rd(32'h100, "lanes_3_0");
    wr(32'h100, 4'b0110, 32'h00EEFF00, "lane21_write");
    rd(32'h100, "lanes_2_1");

    // Output gating
    step(1'b1, 1'b0, 1'b0, 32'h100, 4'h0, 32'h0, "ce_low");
    step(1'b1, 1'b0, 1'b1, 32'h100, 4'hF, 32'h55555555, "ce_low_we");
    wr(32'h100, 4'h0, 32'h01020304, "sel_zero_write");
    rd(32'h100, "after_sel_zero");

    // Wrap-around
    wr(32'h0008_0004, 4'hF, 32'hCAFEF00D, "wrap_write");
    rd(32'h4, "wrap_read");

    // Mid-cycle asynchronous reset while reading 0x100
    rd(32'h100, "pre_async_reset");
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (data_o !== 32'h0) begin
      bad++;
      $display("FAIL async_reset: data_o=%08h expected=%08h", data_o, 32'h0);
    end
    step(1'b0, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0, "held_reset");
    rd(32'h100, "retained_after_reset");

    // Randomized phase over a small pool of words with aliased addresses
    for (int i = 0; i < 8; i++) begin
      known_idx[i] = int'($urandom_range(0, MEM_NUM - 1));
      wr(32'(known_idx[i]) * 32'd4, 4'hF, $urandom, "rand_init");
    end
    for (int n = 0; n < 300; n++) begin
      k  = int'($urandom_range(0, 7));
      a  = (32'(known_idx[k]) * 32'd4) + 32'($urandom_range(0, 3))
         + (32'($urandom_range(0, 15)) << 19);
      op = int'($urandom_range(0, 5));
      case (op)
        0, 1:    wr(a, 4'($urandom), $urandom, "rand_write");
        2:       step(1'b1, 1'b0, 1'($urandom), a, 4'($urandom), $urandom, "rand_ce_low");
        3:       step(1'b0, 1'($urandom), 1'($urandom), a, 4'hF, $urandom, "rand_reset");
        default: rd(a, "rand_read");
      endcase
    end
    for (int i = 0; i < 8; i++) rd(32'(known_idx[i]) * 32'd4, "rand_final");

    // Drain with a bounded wait
    for (int t = 0; t < 10 && q_exp.size() > 0; t++) @(posedge clk);
    if (q_exp.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d expected=0", q_exp.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_ram_be.md
Name: data_ram_be

Overview:
- Word-organised data memory with byte-lane write enables, serving as the data RAM behind the CPU's MEM-stage load/store port.
- Writes are synchronous on the rising clock edge; reads are combinational, so a load completes in the same cycle it is issued.
- Sits between the processor core's ram_* outputs and its ram_data_i input.

Parameters:
- DATA_W, 32, data bus width in bits (fixed at 4 byte lanes).
- ADDR_W, 32, byte-address bus width.
- MEM_NUM_LOG2, 17, log2 of the word count.
- MEM_NUM, 131072, number of 32-bit words (2**MEM_NUM_LOG2).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-low reset.
- ce  input  1  chip enable, active high.
- we  input  1  write enable, active high (1 = write, 0 = read).
- addr  input  ADDR_W  byte address.
- sel  input  4  byte-lane select, active high.
- data_i  input  DATA_W  write data.
- data_o  output  DATA_W  read data.

Behaviour:
- Word index = addr[MEM_NUM_LOG2+1:2].
  - addr[1:0] are ignored; accesses are always word-aligned.
  - Bits above MEM_NUM_LOG2+1 are ignored, so addresses alias (wrap) modulo 4*MEM_NUM bytes.
- Big-endian lane mapping:
  - sel[3] maps to data[31:24].
  - sel[2] maps to data[23:16].
  - sel[1] maps to data[15:8].
  - sel[0] maps to data[7:0].
- Write: at rising clk, when rst=1, ce=1 and we=1, each byte lane with sel[i]=1 is written from the matching byte of data_i.
  - Lanes with sel[i]=0 keep their old value.
  - sel=4'b0000 with we=1 changes nothing.
- Read (combinational):
  - data_o = mem[word index] when rst=1, ce=1 and we=0.
  - data_o = 0 otherwise: ce=0, we=1, or rst=0.
  - Reads return the full word regardless of sel; the core performs byte/halfword extraction.
  - Latency: 0 cycles. data_o follows addr/ce/we changes within the same cycle.
- Read-after-write: a write committed at edge N is visible on data_o immediately after edge N. A read of the same address during the write cycle (we=1) returns 0, so there is no bypass.
- Reset: rst=0 asynchronously forces data_o to 0 and blocks all writes, including a write coinciding with a clock edge while rst=0.
  - Memory contents are NOT cleared by reset; they are retained across reset.
  - Power-up contents are undefined. The bench must write before reading.
  - Deasserting rst mid-operation resumes normal behaviour from the next edge, with no extra recovery cycle.
- Simultaneous ce=0 and we=1: no write, data_o=0.
- No handshake and no wait states; every access completes in one cycle.
- The implementation holds one storage array per byte lane (four MEM_NUM x 8 arrays) so synthesis infers byte-enabled block RAM. Read logic is purely combinational from the arrays.

Test Plan:
- Reset gating: hold rst=0, drive ce=1, we=1, addr=0x0, sel=4'hF, data_i=0xDEADBEEF for one edge, then release rst and read addr 0x0.
  - data_o=0 during reset.
  - The word is not 0xDEADBEEF, because the earlier write was blocked. Pre-write 0x0 with 0x11111111 to check this.
- Full-word write/read: write 0x12345678 to addr 0x100 with sel=F, then read with we=0.
  - data_o=0x12345678 in the cycle after the write edge.
  - Reading addr 0x103 returns the same word.
- Byte lanes: after 0x12345678 at 0x100, write data_i=0xAABBCCDD with sel=4'b1000, then sel=4'b0001.
  - Read returns 0xAA3456DD.
  - Write sel=4'b0110 with 0x00EEFF00; read returns 0xAAEEFFDD.
- Gating of data_o:
  - With word 0x100 holding 0xAAEEFFDD, ce=0 gives data_o=0.
  - ce=1, we=1, sel=0 gives data_o=0, and a subsequent read is unchanged at 0xAAEEFFDD.
- Wrap-around: write 0xCAFEF00D to addr 0x0008_0004, which exceeds 4*MEM_NUM=0x80000.
  - A read of addr 0x4 returns 0xCAFEF00D.
- Mid-run reset: assert rst=0 asynchronously between edges while reading 0x100.
  - data_o drops to 0 immediately.
  - After deassertion, reading 0x100 returns 0xAAEEFFDD (contents retained).
